// File: rtl/seg_limit_check_pipe.sv
// Segment limit checker: per-channel end-address computation and unsigned
// compare against six programmable segment limits, in a two-stage
// valid/ready pipeline with a sticky first-fault record.
module seg_limit_check_pipe #(
  parameter int CHANNELS = 3,
  parameter int AW       = 32
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           lim_wr_en,
  input  logic [2:0]                                     lim_wr_seg,
  input  logic [AW-1:0]                                  lim_wr_data,
  input  logic                                           grp_valid,
  output logic                                           grp_ready,
  input  logic [CHANNELS-1:0]                            addr_valid,
  input  logic [CHANNELS*AW-1:0]                         addr,
  input  logic [CHANNELS*3-1:0]                          seg,
  input  logic [CHANNELS*3-1:0]                          size,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic [CHANNELS-1:0]                            out_fault,
  output logic                                           out_any_fault,
  output logic                                           flt_pending,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] flt_chan,
  output logic [AW-1:0]                                  flt_addr,
  output logic [2:0]                                     flt_seg,
  input  logic                                           flt_clr
);

  localparam int CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int NSEG = 6;

  function automatic logic [AW-1:0] limit_init(input int unsigned idx);
    logic [31:0] v;
    case (idx)
      0:       v = 32'h04ff_f000;
      1:       v = 32'h0400_0000;
      2:       v = 32'h011f_f000;
      3:       v = 32'h003f_f000;
      4:       v = 32'h003f_f000;
      default: v = 32'h007f_f000;
    endcase
    return AW'(v);
  endfunction

  // Last byte touched by the access; saturates on wrap past the top.
  function automatic logic [AW-1:0] end_addr(input logic [AW-1:0] a,
                                             input logic [2:0]    sz);
    logic [AW-1:0] extra;
    logic [AW:0]   sum;
    case (sz)
      3'd2:    extra = AW'(1);
      3'd3:    extra = AW'(3);
      3'd5:    extra = AW'(7);
      3'd6:    extra = AW'(15);
      default: extra = '0;
    endcase
    sum = {1'b0, a} + {1'b0, extra};
    return sum[AW] ? '1 : sum[AW-1:0];
  endfunction

  logic [AW-1:0] lim [NSEG];

  // Limit registers; writes to segment codes 6/7 hit no register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NSEG; i++) lim[i] <= limit_init(i);
    end else if (lim_wr_en) begin
      for (int unsigned i = 0; i < NSEG; i++)
        if (lim_wr_seg == 3'(i)) lim[i] <= lim_wr_data;
    end
  end

  logic [AW-1:0] in_end [CHANNELS];
  logic [AW-1:0] in_lim [CHANNELS];

  // Stage-1 inputs: end address and selected limit (0 for codes 6/7).
  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      in_end[c] = end_addr(addr[c*AW +: AW], size[c*3 +: 3]);
      in_lim[c] = '0;
      for (int unsigned j = 0; j < NSEG; j++)
        if (seg[c*3 +: 3] == 3'(j)) in_lim[c] = lim[j];
    end
  end

  logic                s1_valid, s2_valid, s1_adv, s2_adv;
  logic [CHANNELS-1:0] s1_av, s1_fault, s2_fault;
  logic [AW-1:0]       s1_end  [CHANNELS];
  logic [AW-1:0]       s1_lim  [CHANNELS];
  logic [AW-1:0]       s1_addr [CHANNELS];
  logic [2:0]          s1_seg  [CHANNELS];
  logic [AW-1:0]       s2_addr [CHANNELS];
  logic [2:0]          s2_seg  [CHANNELS];

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = s2_adv || !s1_valid;
  assign grp_ready = s1_adv;

  // Stage 1: capture the limit at acceptance so later writes cannot alter it.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_av    <= '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        s1_end[c]  <= '0;
        s1_lim[c]  <= '0;
        s1_addr[c] <= '0;
        s1_seg[c]  <= '0;
      end
    end else if (s1_adv) begin
      s1_valid <= grp_valid;
      if (grp_valid) begin
        s1_av <= addr_valid;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          s1_end[c]  <= in_end[c];
          s1_lim[c]  <= in_lim[c];
          s1_addr[c] <= addr[c*AW +: AW];
          s1_seg[c]  <= seg[c*3 +: 3];
        end
      end
    end
  end

  // Per-channel violation: valid and end not strictly below the limit.
  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++)
      s1_fault[c] = s1_av[c] && (s1_end[c] >= s1_lim[c]);
  end

  // Stage 2: registered compare results; held while stalled downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_fault <= '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        s2_addr[c] <= '0;
        s2_seg[c]  <= '0;
      end
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      s2_fault <= s1_valid ? s1_fault : '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        s2_addr[c] <= s1_addr[c];
        s2_seg[c]  <= s1_seg[c];
      end
    end
  end

  assign out_valid     = s2_valid;
  assign out_fault     = s2_fault;
  assign out_any_fault = |s2_fault;

  logic          ff_found;
  logic [CW-1:0] ff_chan;
  logic [AW-1:0] ff_addr;
  logic [2:0]    ff_seg;

  // Lowest-index faulting channel of the group at the output.
  always_comb begin
    ff_found = 1'b0;
    ff_chan  = '0;
    ff_addr  = '0;
    ff_seg   = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (!ff_found && s2_fault[c]) begin
        ff_found = 1'b1;
        ff_chan  = CW'(c);
        ff_addr  = s2_addr[c];
        ff_seg   = s2_seg[c];
      end
    end
  end

  logic capture;
  // A clear in the same cycle re-arms capture, so the new fault wins.
  assign capture = out_valid && out_ready && out_any_fault && (!flt_pending || flt_clr);

  // Sticky first-fault record.
  always_ff @(posedge clk) begin
    if (reset) begin
      flt_pending <= 1'b0;
      flt_chan    <= '0;
      flt_addr    <= '0;
      flt_seg     <= '0;
    end else if (capture) begin
      flt_pending <= 1'b1;
      flt_chan    <= ff_chan;
      flt_addr    <= ff_addr;
      flt_seg     <= ff_seg;
    end else if (flt_clr) begin
      flt_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_limit_check_pipe.sv
// Self-checking bench for seg_limit_check_pipe: directed scenarios followed by
// randomized traffic, checked against an arithmetic reference model.
module tb_seg_limit_check_pipe;
  localparam int CH = 3;
  localparam int AW = 32;

  logic             clk = 1'b0;
  logic             reset, lim_wr_en, grp_valid, grp_ready, out_valid, out_ready;
  logic [2:0]       lim_wr_seg;
  logic [AW-1:0]    lim_wr_data;
  logic [CH-1:0]    addr_valid, out_fault;
  logic [CH*AW-1:0] addr;
  logic [CH*3-1:0]  seg, size;
  logic             out_any_fault, flt_pending, flt_clr;
  logic [1:0]       flt_chan;
  logic [AW-1:0]    flt_addr;
  logic [2:0]       flt_seg;

  seg_limit_check_pipe #(.CHANNELS(CH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .lim_wr_en(lim_wr_en), .lim_wr_seg(lim_wr_seg),
    .lim_wr_data(lim_wr_data), .grp_valid(grp_valid), .grp_ready(grp_ready),
    .addr_valid(addr_valid), .addr(addr), .seg(seg), .size(size),
    .out_valid(out_valid), .out_ready(out_ready), .out_fault(out_fault),
    .out_any_fault(out_any_fault), .flt_pending(flt_pending), .flt_chan(flt_chan),
    .flt_addr(flt_addr), .flt_seg(flt_seg), .flt_clr(flt_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0] f;
    int unsigned   ch;
    logic [31:0]   a;
    logic [2:0]    s;
  } exp_t;

  int            tests = 0, fails = 0, cyc = 0, last_acc = 0, last_xfer = 0;
  logic [31:0]   mlim [8];
  exp_t          q [$];
  logic [CH-1:0] dlv [$];
  logic          mp = 1'b0;
  int unsigned   mch = 0;
  logic [31:0]   ma = '0;
  logic [2:0]    ms = '0;
  logic          pv = 1'b0, pr = 1'b0, last_grp_ready = 1'b0;
  logic [CH-1:0] pf = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model_limits();
    mlim[0] = 32'h04ff_f000; mlim[1] = 32'h0400_0000; mlim[2] = 32'h011f_f000;
    mlim[3] = 32'h003f_f000; mlim[4] = 32'h003f_f000; mlim[5] = 32'h007f_f000;
    mlim[6] = '0;            mlim[7] = '0;
  endtask

  function automatic exp_t model(input logic [CH-1:0] av, input logic [CH*AW-1:0] ad,
                                 input logic [CH*3-1:0] sg, input logic [CH*3-1:0] sz);
    exp_t e;
    longint unsigned a, x, en, lm;
    int unsigned s;
    bit found;
    e.f = '0; e.ch = 0; e.a = '0; e.s = '0; found = 0;
    for (int c = 0; c < CH; c++) begin
      a = ad[c*AW +: AW];
      s = sg[c*3 +: 3];
      case (sz[c*3 +: 3])
        3'd2: x = 1;
        3'd3: x = 3;
        3'd5: x = 7;
        3'd6: x = 15;
        default: x = 0;
      endcase
      en = a + x;
      if (en > 64'hFFFF_FFFF) en = 64'hFFFF_FFFF;
      lm = (s < 6) ? mlim[s] : 0;
      if (av[c] && en >= lm) begin
        e.f[c] = 1'b1;
        if (!found) begin found = 1; e.ch = c; e.a = a[31:0]; e.s = s[2:0]; end
      end
    end
    return e;
  endfunction

  function automatic logic [CH-1:0] get_dlv(input int i);
    return (dlv.size() > i) ? dlv[i] : 'x;
  endfunction

  task automatic set_ch(input int c, input logic v, input logic [31:0] a,
                        input logic [2:0] s, input logic [2:0] z);
    addr_valid[c] = v; addr[c*AW +: AW] = a; seg[c*3 +: 3] = s; size[c*3 +: 3] = z;
  endtask

  task automatic idle();
    grp_valid = 0; addr_valid = '0; addr = '0; seg = '0; size = '0;
  endtask

  task automatic rand_group();
    logic [2:0] s;
    logic [31:0] base;
    grp_valid = ($urandom_range(0, 3) != 0);
    for (int c = 0; c < CH; c++) begin
      s = 3'($urandom_range(0, 7));
      base = (s < 6) ? mlim[s] : $urandom;
      case ($urandom_range(0, 4))
        0:       base = $urandom;
        1:       base = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
        default: base = base + 32'($urandom_range(0, 40)) - 32'd20;
      endcase
      set_ch(c, $urandom_range(0, 3) != 0, base, s, 3'($urandom_range(0, 7)));
    end
  endtask

  // One clock: sample at negedge, update the model, check the fault record after the edge.
  task automatic tick();
    exp_t e;
    logic acc, xf;
    @(negedge clk);
    cyc++;
    if (reset) begin
      q.delete(); reset_model_limits(); mp = 0; pv = 0;
    end else begin
      if (pv && !pr) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_hold", out_fault, pf);
      end
      acc = grp_valid && grp_ready;
      xf  = out_valid && out_ready;
      last_grp_ready = grp_ready;
      if (xf) begin
        if (q.size() == 0) chk("unexpected_output", out_valid, 0);
        else begin
          e = q.pop_front();
          chk("out_fault", out_fault, e.f);
          chk("out_any_fault", out_any_fault, |e.f);
          dlv.push_back(out_fault);
          last_xfer = cyc;
          if (e.f != 0 && (!mp || flt_clr)) begin
            mp = 1; mch = e.ch; ma = e.a; ms = e.s;
          end else if (flt_clr) mp = 0;
        end
      end else if (flt_clr) mp = 0;
      if (acc) begin
        q.push_back(model(addr_valid, addr, seg, size));
        last_acc = cyc;
      end
      if (lim_wr_en && lim_wr_seg < 6) mlim[lim_wr_seg] = lim_wr_data;
      pv = out_valid; pr = out_ready; pf = out_fault;
    end
    @(posedge clk);
    #1;
    chk("flt_pending", flt_pending, mp);
    if (mp) begin
      chk("flt_chan", flt_chan, mch);
      chk("flt_addr", flt_addr, ma);
      chk("flt_seg", flt_seg, ms);
    end
  endtask

  initial begin
    reset = 1; lim_wr_en = 0; lim_wr_seg = '0; lim_wr_data = '0;
    out_ready = 1; flt_clr = 0;
    idle();
    reset_model_limits();
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_fault", out_fault, 0);
    chk("rst_any_fault", out_any_fault, 0);
    chk("rst_flt_chan", flt_chan, 0);
    chk("rst_flt_addr", flt_addr, 0);
    chk("rst_flt_seg", flt_seg, 0);
    reset = 0;
    chk("rst_grp_ready", grp_ready, 1);

    // DS limit boundary, size 3
    dlv.delete();
    grp_valid = 1;
    set_ch(0, 1, 32'h011f_effb, 3'd2, 3'd3);
    set_ch(1, 1, 32'h011f_effd, 3'd2, 3'd3);
    tick(); idle(); tick(); tick();
    chk("ds_boundary", get_dlv(0), 3'b010);
    chk("latency", last_xfer - last_acc, 2);
    chk("ds_flt_chan", flt_chan, 1);
    flt_clr = 1; tick(); flt_clr = 0;

    // Carry saturation, and the same access with addr_valid low
    dlv.delete();
    grp_valid = 1;
    set_ch(0, 1, 32'hFFFF_FFFF, 3'd0, 3'd5);
    set_ch(1, 0, 32'hFFFF_FFFF, 3'd0, 3'd5);
    tick(); idle(); tick(); tick();
    chk("carry_sat", get_dlv(0), 3'b001);

    // Limit write timing
    dlv.delete();
    lim_wr_en = 1; lim_wr_seg = 3'd2; lim_wr_data = 32'h0000_1000;
    grp_valid = 1;
    set_ch(0, 1, 32'h0000_2000, 3'd2, 3'd0);
    tick();
    lim_wr_en = 0;
    tick(); idle(); tick(); tick();
    chk("wr_same_cycle", get_dlv(0), 3'b000);
    chk("wr_next_cycle", get_dlv(1), 3'b001);
    lim_wr_en = 1; lim_wr_data = 32'h011f_f000; flt_clr = 1;
    tick();
    lim_wr_en = 0; flt_clr = 0;

    // Backpressure with two groups queued
    dlv.delete();
    out_ready = 0; grp_valid = 1;
    set_ch(2, 1, $urandom, 3'd7, 3'd0); tick();
    idle(); grp_valid = 1; set_ch(0, 1, $urandom, 3'd7, 3'd0); tick();
    idle(); grp_valid = 1; set_ch(1, 1, $urandom, 3'd7, 3'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_grp_ready", last_grp_ready, 0);
      chk("stall_out_fault", out_fault, 3'b100);
    end
    out_ready = 1;
    tick();
    chk("release_grp_ready", last_grp_ready, 1);
    for (int i = 0; i < 4; i++) begin
      idle(); grp_valid = 1; set_ch(i % CH, 1, 32'h0000_0010, 3'd1, 3'd0);
      tick();
      chk("throughput_grp_ready", last_grp_ready, 1);
    end
    idle(); tick(); tick();
    chk("order_g1", get_dlv(0), 3'b100);
    chk("order_g2", get_dlv(1), 3'b001);
    chk("order_g3", get_dlv(2), 3'b010);
    chk("order_count", dlv.size(), 7);
    flt_clr = 1; tick(); flt_clr = 0;

    // First-fault capture, hold, and clear coincident with a new capture
    grp_valid = 1; set_ch(2, 1, 32'h1234_5678, 3'd7, 3'd0); tick();
    idle(); grp_valid = 1; set_ch(0, 1, 32'h0000_0100, 3'd6, 3'd0); tick();
    idle(); grp_valid = 1; set_ch(1, 1, 32'h0abc_def0, 3'd7, 3'd2); tick();
    idle();
    chk("first_chan", flt_chan, 2);
    tick();
    chk("held_chan", flt_chan, 2);
    flt_clr = 1; tick(); flt_clr = 0;
    chk("clr_capture_chan", flt_chan, 1);
    chk("clr_capture_pending", flt_pending, 1);

    // seg 7 faults; reset mid-stream restores limits
    dlv.delete();
    lim_wr_en = 1; lim_wr_seg = 3'd2; lim_wr_data = '0; tick(); lim_wr_en = 0;
    for (int i = 0; i < 3; i++) begin
      grp_valid = 1;
      for (int c = 0; c < CH; c++) set_ch(c, 1, $urandom, 3'd7, 3'($urandom_range(0, 7)));
      tick();
    end
    chk("seg7_all", get_dlv(0), 3'b111);
    reset = 1; tick(); reset = 0; idle();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_grp_ready", grp_ready, 1);
    dlv.delete();
    grp_valid = 1; set_ch(0, 1, 32'h011f_effb, 3'd2, 3'd3); tick();
    idle(); tick(); tick();
    chk("limit_restored", get_dlv(0), 3'b000);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_group();
      out_ready = ($urandom_range(0, 3) != 0);
      flt_clr   = ($urandom_range(0, 7) == 0);
      lim_wr_en = ($urandom_range(0, 15) == 0);
      lim_wr_seg  = 3'($urandom_range(0, 7));
      lim_wr_data = $urandom & 32'h07ff_f000;
      tick();
    end
    idle(); out_ready = 1; flt_clr = 0; lim_wr_en = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("drain_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
